audio_fifo: RTL and testbench

//  Sample buffer and rate pacer directly upstream of audio_dac. Accepts 32-bit stereo words
//  {right[31:16], left[15:0]} from the bus/DMA side, holds DEPTH entries, and presents the FIFO

---
 rtl/audio_fifo.sv | 153 +++++++++++++++
 tb/tb_audio_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : audio_fifo
// Purpose  : Stereo sample FIFO with sample-rate tick pacer feeding audio_dac.
//            Optional underrun counter enabled by defining AUDIO_FIFO_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_fifo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inport_tvalid_i,
    input  logic [31:0]       inport_tdata_i,
    output logic              inport_tready_o,
    output logic              outport_tvalid_o,
    output logic [31:0]       outport_tdata_o,
    output logic [3:0]        outport_tstrb_o,
    output logic [3:0]        outport_tdest_o,
    output logic              outport_tlast_o,
    input  logic              outport_tready_i,
    output logic              sample_tick_o,
    input  logic              cfg_enable_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [ADDR_W:0]   cfg_thresh_i,
    input  logic              flush_i,
    output logic [ADDR_W:0]   level_o,
    output logic              low_irq_o,
    output logic              underrun_o
`ifdef AUDIO_FIFO_STATS_EN
    ,
    output logic [15:0]       underrun_cnt_o
`endif
);

    localparam logic [ADDR_W:0]   c_level_full = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_level_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  c_div_one    = DIV_W'(1);
    localparam logic [DIV_W-1:0]  c_div_min    = DIV_W'(2);

    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_tick;
    logic              r_underrun;
    logic              r_low_irq;

    logic              w_push;
    logic              w_pop;
    logic [DIV_W-1:0]  w_div_eff;
    logic              w_div_last;

    assign inport_tready_o  = (r_level != c_level_full) && !flush_i;
    assign outport_tvalid_o = (r_level != '0);
    assign w_push           = inport_tvalid_i && inport_tready_o;
    assign w_pop            = outport_tready_i && outport_tvalid_o;

    // Head is gated so stale storage never appears on the bus while empty.
    assign outport_tdata_o  = outport_tvalid_o ? r_mem[r_rd_ptr] : '0;
    assign outport_tstrb_o  = 4'hF;
    assign outport_tdest_o  = 4'h0;
    assign outport_tlast_o  = 1'b1;

    assign level_o          = r_level;
    assign low_irq_o        = r_low_irq;
    assign sample_tick_o    = r_tick;
    assign underrun_o       = r_underrun;

    assign w_div_eff  = (cfg_div_i < c_div_min) ? c_div_min : cfg_div_i;
    // >= rather than == so a divider shrunk below the current count still wraps.
    assign w_div_last = (r_div_cnt >= (w_div_eff - c_div_one));

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= inport_tdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_low_irq <= 1'b0;
        end else begin
            r_low_irq <= (r_level <= cfg_thresh_i);
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + c_level_one;
                end else if (!w_push && w_pop) begin
                    r_level <= r_level - c_level_one;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (!cfg_enable_i) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (w_div_last) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_one;
            r_tick    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= r_tick && (r_level == '0);
        end
    end

`ifdef AUDIO_FIFO_STATS_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_underrun_cnt <= '0;
        end else if (flush_i) begin
            r_underrun_cnt <= '0;
        end else if (r_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt_o = r_underrun_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_fifo
// Purpose  : Scoreboard bench for audio_fifo: fill, pacing, underrun,
//            simultaneous push/pop, flush and minimum divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        inport_tvalid_i = 1'b0;
    logic [31:0] inport_tdata_i = '0;
    logic        inport_tready_o;
    logic        outport_tvalid_o;
    logic [31:0] outport_tdata_o;
    logic [3:0]  outport_tstrb_o;
    logic [3:0]  outport_tdest_o;
    logic        outport_tlast_o;
    logic        outport_tready_i;
    logic        sample_tick_o;
    logic        cfg_enable_i = 1'b0;
    logic [15:0] cfg_div_i = 16'd4;
    logic [6:0]  cfg_thresh_i = 7'd8;
    logic        flush_i = 1'b0;
    logic [6:0]  level_o;
    logic        low_irq_o;
    logic        underrun_o;
`ifdef AUDIO_FIFO_STATS_EN
    logic [15:0] underrun_cnt_o;
`endif

    logic        dac_en = 1'b0;
    logic        dac_ready = 1'b0;
    logic        man_ready = 1'b0;
    assign outport_tready_i = dac_en ? dac_ready : man_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    int          pops = 0;
    int          ur_count = 0;
    int          ticks_seen = 0;
    int          exp_period = 0;
    int          last_tick = -1;
    int          cyc = 0;
    logic        prev_ur = 1'b0;

    audio_fifo dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .inport_tvalid_i  (inport_tvalid_i),
        .inport_tdata_i   (inport_tdata_i),
        .inport_tready_o  (inport_tready_o),
        .outport_tvalid_o (outport_tvalid_o),
        .outport_tdata_o  (outport_tdata_o),
        .outport_tstrb_o  (outport_tstrb_o),
        .outport_tdest_o  (outport_tdest_o),
        .outport_tlast_o  (outport_tlast_o),
        .outport_tready_i (outport_tready_i),
        .sample_tick_o    (sample_tick_o),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_thresh_i     (cfg_thresh_i),
        .flush_i          (flush_i),
        .level_o          (level_o),
        .low_irq_o        (low_irq_o),
        .underrun_o       (underrun_o)
`ifdef AUDIO_FIFO_STATS_EN
        ,
        .underrun_cnt_o   (underrun_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // DAC model: latch head on a tick, assert ready during the following cycle.
    initial begin
        logic prev_tick;
        prev_tick = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            dac_ready = prev_tick;
            prev_tick = sample_tick_o;
        end
    end

    // Monitor: compares every handshake against the scoreboard, tracks ticks/underruns.
    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (outport_tvalid_o && outport_tready_i && !flush_i) begin
                pops++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%08h expected none", outport_tdata_o);
                end else begin
                    exp_word = sb.pop_front();
                    if (outport_tdata_o !== exp_word) begin
                        errors++;
                        $display("FAIL pop_data: got 0x%08h expected 0x%08h", outport_tdata_o, exp_word);
                    end
                end
            end
            if (sample_tick_o) begin
                ticks_seen++;
                if (exp_period != 0 && last_tick >= 0) begin
                    checks++;
                    if (cyc - last_tick != exp_period) begin
                        errors++;
                        $display("FAIL tick_period: got %0d expected %0d", cyc - last_tick, exp_period);
                    end
                end
                last_tick = cyc;
            end
            if (underrun_o) begin
                ur_count++;
                checks++;
                if (prev_ur) begin
                    errors++;
                    $display("FAIL underrun_width: got 2+ cycles expected 1");
                end
            end
            prev_ur = underrun_o;
        end
    end

    initial begin
        bit done;

        // Reset
        #12;
        check("rst_tvalid", 32'(outport_tvalid_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_tick", 32'(sample_tick_o), 32'd0);
        check("rst_low_irq", 32'(low_irq_o), 32'd0);
        check("rst_tdata", outport_tdata_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cyc_wait(1);
        check("post_rst_tready", 32'(inport_tready_o), 32'd1);
        check("post_rst_low_irq", 32'(low_irq_o), 32'd1);
        check("tstrb", 32'(outport_tstrb_o), 32'hF);
        check("tlast", 32'(outport_tlast_o), 32'd1);

        // Fill 64, attempt a 65th
        for (int i = 0; i < 65; i++) begin
            inport_tvalid_i = 1'b1;
            inport_tdata_i  = 32'h0001_0000 + 32'(i);
            if (i < 64) sb.push_back(inport_tdata_i);
            cyc_wait(1);
        end
        inport_tvalid_i = 1'b0;
        cyc_wait(1);
        check("full_level", 32'(level_o), 32'd64);
        check("full_tready", 32'(inport_tready_o), 32'd0);
        check("full_low_irq", 32'(low_irq_o), 32'd0);
        check("full_head", outport_tdata_o, 32'h0001_0000);
        man_ready = 1'b1;
        cyc_wait(64);
        man_ready = 1'b0;
        cyc_wait(1);
        check("drain_level", 32'(level_o), 32'd0);
        check("drain_tvalid", 32'(outport_tvalid_o), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Pacing: 10 samples through the DAC model at div 4
        for (int i = 0; i < 10; i++) begin
            inport_tvalid_i = 1'b1;
            inport_tdata_i  = 32'h0002_0000 + 32'(i);
            sb.push_back(inport_tdata_i);
            cyc_wait(1);
        end
        inport_tvalid_i = 1'b0;
        pops = 0;
        dac_en = 1'b1;
        cfg_div_i = 16'd4;
        exp_period = 4;
        last_tick = -1;
        cfg_enable_i = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            cyc_wait(1);
            if (level_o == 7'd0) done = 1'b1;
        end
        cfg_enable_i = 1'b0;
        check("pace_done", 32'(done), 32'd1);
        check("pace_pops", 32'(pops), 32'd10);
        check("pace_no_underrun", 32'(ur_count), 32'd0);
        cyc_wait(2);

        // Underrun: one word, second tick finds the FIFO empty
        ur_count = 0;
        inport_tvalid_i = 1'b1;
        inport_tdata_i  = 32'h0003_0000;
        sb.push_back(inport_tdata_i);
        cyc_wait(1);
        inport_tvalid_i = 1'b0;
        last_tick = -1;
        cfg_enable_i = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk_i);
            if (ur_count > 0) done = 1'b1;
        end
        cfg_enable_i = 1'b0;
        cyc_wait(3);
        check("underrun_seen", 32'(done), 32'd1);
        check("underrun_count", 32'(ur_count), 32'd1);
        check("underrun_level", 32'(level_o), 32'd0);
`ifdef AUDIO_FIFO_STATS_EN
        check("underrun_cnt_o", 32'(underrun_cnt_o), 32'd1);
`endif
        dac_en = 1'b0;
        exp_period = 0;

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) begin
            inport_tvalid_i = 1'b1;
            inport_tdata_i  = 32'h0005_0000 + 32'(i);
            sb.push_back(inport_tdata_i);
            cyc_wait(1);
        end
        check("simul_pre_level", 32'(level_o), 32'd5);
        inport_tdata_i = 32'h0005_0005;
        sb.push_back(inport_tdata_i);
        man_ready = 1'b1;
        cyc_wait(1);
        inport_tvalid_i = 1'b0;
        man_ready = 1'b0;
        check("simul_level", 32'(level_o), 32'd5);
        check("simul_head", outport_tdata_o, 32'h0005_0001);
        man_ready = 1'b1;
        cyc_wait(5);
        man_ready = 1'b0;
        check("simul_drain_level", 32'(level_o), 32'd0);

        // Flush at level 20 with a concurrent push
        for (int i = 0; i < 20; i++) begin
            inport_tvalid_i = 1'b1;
            inport_tdata_i  = 32'h0006_0000 + 32'(i);
            sb.push_back(inport_tdata_i);
            cyc_wait(1);
        end
        check("flush_pre_level", 32'(level_o), 32'd20);
        inport_tdata_i = 32'h0006_DEAD;
        flush_i = 1'b1;
        sb.delete();
        cyc_wait(1);
        flush_i = 1'b0;
        inport_tvalid_i = 1'b0;
        check("flush_level", 32'(level_o), 32'd0);
        check("flush_tvalid", 32'(outport_tvalid_o), 32'd0);
        inport_tvalid_i = 1'b1;
        inport_tdata_i  = 32'h0006_0100;
        sb.push_back(inport_tdata_i);
        cyc_wait(1);
        inport_tvalid_i = 1'b0;
        check("flush_post_head", outport_tdata_o, 32'h0006_0100);
        man_ready = 1'b1;
        cyc_wait(1);
        man_ready = 1'b0;
        check("flush_post_level", 32'(level_o), 32'd0);

        // Divider below 2 behaves as 2
        ticks_seen = 0;
        last_tick = -1;
        exp_period = 2;
        cfg_div_i = 16'd1;
        cfg_enable_i = 1'b1;
        cyc_wait(12);
        cfg_enable_i = 1'b0;
        cyc_wait(2);
        exp_period = 0;
        check("div_min_ticks", 32'(ticks_seen >= 5), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
